// File: rtl/cic_pkg.sv
// Shared constants and helpers for the CIC interpolating PDM transmitter.
package cic_pkg;

    // Number of comb and integrator stages in the CIC filter.
    localparam int N_STAGES = 3;

    // Internal datapath width. The interpolating CIC grows by N_STAGES*LOG2R bits.
    function automatic int acc_w(input int in_w, input int log2r);
        return in_w + N_STAGES * log2r;
    endfunction

    // Two's complement to offset binary: invert the sign bit of a w-bit value.
    // The caller truncates the result to w bits.
    function automatic logic [31:0] offset_bin(input logic [31:0] x, input int w);
        return x ^ (32'd1 << (w - 1));
    endfunction

endpackage

// File: rtl/pdm_sd_mod.sv
// First-order delta-sigma modulator: each clk {carry, acc} <= acc + u and the
// carry becomes the PDM bit. Ones density equals u / 2^W.
module pdm_sd_mod #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] u,
    output logic         pdm_out
);

    logic [W-1:0] acc_q;
    logic         pdm_q;
    logic [W:0]   sum_d;

    assign sum_d = {1'b0, acc_q} + {1'b0, u};

    // Accumulate u every clk and register the carry out as the PDM bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            pdm_q <= 1'b0;
        end else begin
            acc_q <= sum_d[W-1:0];
            pdm_q <= sum_d[W];
        end
    end

    assign pdm_out = pdm_q;

endmodule

// File: rtl/cic_interp_pdm_tx.sv
// CIC interpolating PDM transmitter.
//
// PCM samples arrive through a valid/ready handshake once every R = 2^LOG2R
// clocks (ready is high only while the phase counter sits at R-1). The held
// sample drives a 3-stage CIC interpolator: combs at the sample rate, zero
// stuffing, integrators at clk rate. The last integrator output is scaled by
// 1/R^2, saturated to IN_W bits and fed to a first-order delta-sigma modulator
// producing one PDM bit per clk.
//
// Latency: the comb fires on the phase-0 cycle following a transfer slot.
// Counting registered stages from that fire: comb register (1), three
// pipelined integrators (3), modulator output register (1). If the fire
// happens in cycle p, the first pdm_out bit affected appears in cycle p+5.
//
// underrun is decoded from the registered ready flag and in_valid, so it is
// high during the phase R-1 cycle of a slot that passes without a transfer,
// and reads 0 whenever the block is in reset.
module cic_interp_pdm_tx
    import cic_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int LOG2R = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [IN_W-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   pdm_out,
    output logic                   underrun
);

    localparam int ACC_W = acc_w(IN_W, LOG2R);
    localparam int SHIFT = 2 * LOG2R;
    localparam int SC_W  = ACC_W - SHIFT;

    localparam logic [LOG2R-1:0]       PH_LAST = '1;
    localparam logic signed [SC_W-1:0] SAT_HI  = SC_W'((1 << (IN_W - 1)) - 1);
    localparam logic signed [SC_W-1:0] SAT_LO  = -SAT_HI - SC_W'(1);

    // ------------------------------------------------------------------
    // Slot timing and input handshake
    // ------------------------------------------------------------------
    logic [LOG2R-1:0]       phase_q, phase_d;
    logic                   ready_q, ready_d;
    logic signed [IN_W-1:0] held_q, held_d;
    logic                   xfer;
    logic                   fire;

    assign phase_d = phase_q + LOG2R'(1);
    // Ready is registered from the next phase so it is high exactly while
    // phase_q == R-1.
    assign ready_d = (phase_d == PH_LAST);
    assign xfer    = ready_q & in_valid;
    assign held_d  = xfer ? in_data : held_q;
    // The comb fires on phase 0; a transfer happens at phase R-1, so the comb
    // always sees the sample latched on the previous edge.
    assign fire    = (phase_q == '0);

    assign in_ready = ready_q;
    assign underrun = ready_q & ~in_valid;

    // Phase counter, ready flag and held sample.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before the edge, independent of order.
        if (!rst) begin
            phase_q <= '0;
            ready_q <= 1'b0;
            held_q  <= '0;
        end else begin
            phase_q <= phase_d;
            ready_q <= ready_d;
            held_q  <= held_d;
        end
    end

    // ------------------------------------------------------------------
    // Comb section: N_STAGES first differences, updated once per slot
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] comb_x     [N_STAGES+1];
    logic signed [ACC_W-1:0] comb_dly_q [N_STAGES];
    logic signed [ACC_W-1:0] comb_q, comb_d;

    assign comb_x[0] = {{(ACC_W-IN_W){held_q[IN_W-1]}}, held_q};

    for (genvar i = 0; i < N_STAGES; i++) begin : g_comb
        assign comb_x[i+1] = comb_x[i] - comb_dly_q[i];
    end

    // Zero stuffing: the comb result enters the integrators for one clk only.
    assign comb_d = fire ? comb_x[N_STAGES] : '0;

    // Comb delay elements (updated on fire only) and the zero-stuffed output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: this small register array is cleared element by element
            // because the filter state must restart from zero after reset.
            for (int i = 0; i < N_STAGES; i++) comb_dly_q[i] <= '0;
            comb_q <= '0;
        end else begin
            for (int i = 0; i < N_STAGES; i++) begin
                if (fire) comb_dly_q[i] <= comb_x[i];
            end
            comb_q <= comb_d;
        end
    end

    // ------------------------------------------------------------------
    // Integrator section: N_STAGES pipelined accumulators at clk rate.
    // Two's complement wrap is harmless: the final value is exact modulo
    // 2^ACC_W and always fits.
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] int_q [N_STAGES];
    logic signed [ACC_W-1:0] int_d [N_STAGES];

    for (genvar i = 0; i < N_STAGES; i++) begin : g_int
        if (i == 0) begin : g_first
            assign int_d[i] = int_q[i] + comb_q;
        end else begin : g_next
            assign int_d[i] = int_q[i] + int_q[i-1];
        end
    end

    // Integrator registers, one pipeline stage each.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_STAGES; i++) int_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_STAGES; i++) int_q[i] <= int_d[i];
        end
    end

    // ------------------------------------------------------------------
    // Gain removal and saturation
    // ------------------------------------------------------------------
    logic signed [SC_W-1:0] scaled;
    logic signed [IN_W-1:0] sat;
    logic [IN_W-1:0]        mod_u;

    // Dropping the low 2*LOG2R bits is an arithmetic shift right by the R^2 gain.
    assign scaled = int_q[N_STAGES-1][ACC_W-1:SHIFT];

    // Clamp the scaled value to the signed IN_W range.
    always_comb begin
        // NOTE: the default assignment first keeps every path assigned, so no
        // latch is inferred.
        sat = scaled[IN_W-1:0];
        if (scaled > SAT_HI) begin
            sat = {1'b0, {(IN_W-1){1'b1}}};
        end else if (scaled < SAT_LO) begin
            sat = {1'b1, {(IN_W-1){1'b0}}};
        end
    end

    assign mod_u = IN_W'(offset_bin(32'(sat), IN_W));

    // ------------------------------------------------------------------
    // Delta-sigma modulator
    // ------------------------------------------------------------------
    pdm_sd_mod #(
        .W (IN_W)
    ) u_mod (
        .clk     (clk),
        .rst     (rst),
        .u       (mod_u),
        .pdm_out (pdm_out)
    );

endmodule

// File: tb/tb_cic_interp_pdm_tx.sv
// Self-checking bench for cic_interp_pdm_tx. A behavioural model evaluates the
// CIC as a convolution of the zero-stuffed sample stream with the cubed boxcar
// kernel, then scales, clamps and runs an ideal accumulator modulator. Expected
// per-cycle outputs go into a queue that a negedge monitor pops and compares.
module tb_cic_interp_pdm_tx;

    localparam int IN_W  = 16;
    localparam int LOG2R = 6;
    localparam int R     = 1 << LOG2R;
    localparam int HLEN  = 3 * R - 2;
    localparam int LAT   = 4;   // fire cycle to the integrator output feeding the modulator

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic signed [IN_W-1:0] in_data = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic                   pdm_out;
    logic                   underrun;

    always #5 clk = ~clk;

    cic_interp_pdm_tx #(
        .IN_W  (IN_W),
        .LOG2R (LOG2R)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .pdm_out  (pdm_out),
        .underrun (underrun)
    );

    int n_checks  = 0;
    int n_fail    = 0;
    int under_cnt = 0;
    int ones_cnt  = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input longint got, input longint lo, input longint hi);
        n_checks++;
        if (got < lo || got > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, got, lo, hi, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct { int cyc; longint val; } fire_t;
    typedef struct { bit pdm; bit ready; } exp_t;

    longint h [HLEN];
    fire_t  fires [$];
    exp_t   exp_q [$];
    int     mdl_n    = 0;   // index of the current cycle since reset release
    longint mdl_held = 0;
    longint mdl_acc  = 0;

    // Cubed boxcar of length R: the impulse response of comb^3 / integrator^3.
    function automatic void build_kernel();
        longint b2 [2*R-1];
        for (int i = 0; i < 2*R-1; i++) b2[i] = 0;
        for (int i = 0; i < HLEN; i++) h[i] = 0;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < R; j++) b2[i+j] += 1;
        for (int i = 0; i < 2*R-1; i++)
            for (int j = 0; j < R; j++) h[i+j] += b2[i];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdl_n    = 0;
            mdl_held = 0;
            mdl_acc  = 0;
            fires.delete();
            exp_q.delete();
        end else begin
            int     c;
            longint y;
            longint sc;
            longint s;
            exp_t   e;
            c = mdl_n;
            if (c % R == 0) begin
                fires.push_back('{c, mdl_held});
                if (fires.size() > 4) void'(fires.pop_front());
            end
            if (c % R == R-1 && in_valid) mdl_held = in_data;
            y = 0;
            foreach (fires[i]) begin
                int k;
                k = c - LAT - fires[i].cyc;
                if (k >= 0 && k < HLEN) y += h[k] * fires[i].val;
            end
            sc = y >>> (2 * LOG2R);
            if (sc > 32767) sc = 32767;
            if (sc < -32768) sc = -32768;
            s = mdl_acc + sc + 32768;
            e.pdm   = (s >= 65536);
            mdl_acc = s % 65536;
            mdl_n   = c + 1;
            e.ready = (mdl_n % R == R-1);
            exp_q.push_back(e);
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (rst && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("pdm_out", pdm_out, e.pdm);
            check("in_ready", in_ready, e.ready);
            check("underrun", underrun, e.ready && !in_valid);
            if (underrun) under_cnt++;
            if (pdm_out) ones_cnt++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    // Drive junk on non-transfer cycles and (d, v) on the phase R-1 cycle.
    task automatic drive_slot(input logic [IN_W-1:0] d, input bit v);
        for (int i = 0; i < R; i++) begin
            if (mdl_n % R == R-1) begin
                in_data  = d;
                in_valid = v;
                @(posedge clk); #1;
                return;
            end
            in_data  = IN_W'($urandom);
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        check("drive_slot_found", 0, 1);
    endtask

    // Hold (d, v) for len cycles and check the ones count in that window.
    task automatic window(input logic [IN_W-1:0] d, input bit v, input int len,
                          input int lo, input int hi, input string name);
        int st;
        in_data  = d;
        in_valid = v;
        st = ones_cnt;
        repeat (len) begin @(posedge clk); #1; end
        check_range(name, ones_cnt - st, lo, hi);
    endtask

    // Release reset with zero input and measure the cycle of the first ready.
    task automatic release_and_find_ready(input string name);
        int k;
        in_data  = '0;
        in_valid = 1'b1;
        rst = 1'b1;
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            if (in_ready) break;
            k++;
        end
        check(name, k, R-1);
        @(posedge clk); #1;
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int st;
        build_kernel();
        @(posedge clk); #1;
        check("reset_pdm", pdm_out, 0);
        check("reset_ready", in_ready, 0);
        check("reset_underrun", underrun, 0);

        // Zero input, valid always high: 0101 pattern, no underrun.
        st = under_cnt;
        release_and_find_ready("first_ready");
        in_data = '0;
        repeat (3 * R) begin @(posedge clk); #1; end
        check("zero_underrun_count", under_cnt - st, 0);

        // Random samples.
        repeat (8) drive_slot(IN_W'($urandom), 1'b1);

        // Positive full scale.
        repeat (6) drive_slot(16'h7FFF, 1'b1);
        window(16'h7FFF, 1'b1, 1024, 1023, 1024, "density_7fff");

        // Negative full scale.
        repeat (6) drive_slot(16'h8000, 1'b1);
        window(16'h8000, 1'b1, 1024, 0, 0, "density_8000");

        // Step from 0 to 0x4000.
        repeat (4) drive_slot(16'h0000, 1'b1);
        repeat (6) drive_slot(16'h4000, 1'b1);
        window(16'h4000, 1'b1, 1024, 767, 769, "density_4000");

        // Three dropped slots: repeat last sample, three underruns.
        drive_slot(16'h2000, 1'b1);
        st = under_cnt;
        repeat (3) drive_slot(16'h7FFF, 1'b0);
        check("underrun_count", under_cnt - st, 3);
        repeat (3) drive_slot(16'h2000, 1'b1);
        window(16'h2000, 1'b1, 1024, 639, 641, "density_2000_hold");

        // Alternating full-scale samples.
        for (int i = 0; i < 8; i++) drive_slot((i % 2 == 0) ? 16'h7FFF : 16'h8000, 1'b1);

        // Random samples with random gaps.
        repeat (12) drive_slot(IN_W'($urandom), ($urandom_range(0, 3) != 0));

        // Mid-slot reset after a nonzero sample.
        drive_slot(16'h3000, 1'b1);
        for (int i = 0; i < R; i++) begin
            if (mdl_n % R == 20) break;
            @(posedge clk); #1;
        end
        check("reset_phase_reached", mdl_n % R, 20);
        #1 rst = 1'b0;
        #1;
        check("async_reset_pdm", pdm_out, 0);
        check("async_reset_ready", in_ready, 0);
        check("async_reset_underrun", underrun, 0);
        repeat (3) @(posedge clk);
        #1;
        st = under_cnt;
        release_and_find_ready("first_ready_after_reset");
        repeat (2 * R) begin @(posedge clk); #1; end
        check("post_reset_underrun_count", under_cnt - st, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog.
    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cic_interp_pdm_tx.md
Name: cic_interp_pdm_tx

Overview:
- PDM transmitter: the output-direction counterpart to the team's 1-bit PDM CIC decimator.
- Accepts signed PCM samples at clk/R through a valid/ready handshake.
- Interpolates by R with a 3-stage CIC (combs at sample rate, zero-stuff, integrators at clk rate), then drives a 1-bit PDM stream at clk rate via a first-order delta-sigma modulator.
- Sits ahead of the DAC/speaker PDM pin.

Parameters:
- IN_W, 16, signed input sample width.
- LOG2R, 6, log2 of the interpolation ratio R (R=64); R is always a power of two.

Ports:
- clk  in  1  system clock; also the PDM bit rate.
- rst  in  1  reset, asynchronous, active-low.
- in_data  in  IN_W  signed PCM sample.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a sample this cycle.
- pdm_out  out  1  PDM bit, one per clk.
- underrun  out  1  one-cycle pulse when a sample slot passes with no transfer.

Behaviour:
- Reset (rst=0, async): all registers clear to 0. This includes phase counter, combs, integrators, held sample, modulator accumulator, pdm_out, in_ready and underrun.
- Phase counter:
  - LOG2R bits, increments every clk, wraps R-1 -> 0.
  - in_ready = 1 only while phase == R-1, registered from phase, so the first in_ready is R-1 cycles after reset release.
- Transfer: in_valid & in_ready at phase R-1 latches in_data into the held sample.
  - in_valid low at phase R-1: held sample is kept (repeat last) and underrun pulses 1 cycle at phase R-1.
  - in_valid outside phase R-1 is ignored; data is not consumed.
- Comb section:
  - Fires once per slot, on the cycle after phase R-1 (phase 0), operating on the held sample.
  - 3 cascaded first-difference stages with differential delay 1.
  - Each stage: y = x - x_prev; x_prev updated on fire only.
- Zero-stuff: integrator input = comb output on the phase-0 cycle, 0 on all other cycles.
- Integrators:
  - 3 cascaded accumulators, updated every clk.
  - All internal datapath is ACC_W = IN_W + 3*LOG2R bits (34 by default), two's complement, wrap-around permitted. Modular arithmetic guarantees a correct final result.
- Scaling: gain is R^2, so the scaled value = last integrator output arithmetically shifted right by 2*LOG2R.
  - Saturate the scaled value to [-2^(IN_W-1), 2^(IN_W-1)-1].
  - Constant input x in steady state yields exactly x.
- Modulator:
  - u = saturated sample with MSB inverted (offset binary, 0..2^IN_W-1).
  - acc is IN_W bits; each clk {carry, acc} <= acc + u; pdm_out <= carry (registered).
  - Ones density = u / 2^IN_W.
- Pipeline: every stage is registered. Total latency from the phase-0 comb fire to the first affected pdm_out bit is 5 clk: 1 comb, 3 integrators, 1 modulator. The implementation must match this exactly and document it in a header comment.
- Simultaneous events: a transfer and the comb fire never coincide; the comb uses the value latched on the previous edge.
- Reset mid-operation: immediately returns to the reset state. Any sample in flight is lost and no underrun is reported for it.

Decomposition:
- Shared package (cic_pkg): N_STAGES=3 constant, function acc_w(in_w, log2r), offset-binary conversion function.
- Sub-module pdm_sd_mod: first-order modulator (input u, clk, rst, output pdm_out).
- Combs and integrators stay inline as generate loops over N_STAGES.

Test Plan:
- Reset release with in_data=0, in_valid=1 always: pdm_out is exactly 0,1,0,1,... from the first modulator update; in_ready pulses every 64 cycles, first at cycle 63; underrun never asserts.
- Constant 0x7FFF: after settling (>=4*R cycles), ones count over any 65536-cycle window = 65535. Constant 0x8000: pdm_out stuck 0.
- Step from 0 to 0x4000 at a transfer: pdm_out is unaffected until 5 cycles after the next phase-0 fire. Ones density settles to 0xC000/0x10000 = 75% ±1 bit per window, with no overshoot above the saturated value.
- in_valid dropped for 3 consecutive slots:
  - underrun pulses exactly 3 times, each at phase 63.
  - Density holds the last sample's value.
  - in_ready timing is unchanged.
- Alternating full-scale samples 0x7FFF/0x8000 each slot: the scaled value hits the saturation bounds; no integrator wrap is visible in the output, and density stays within [0,1] with no pattern inversion.
- Assert rst low mid-slot (phase 20, after a nonzero sample): all outputs read 0 immediately (async). After release, the phase restarts at 0, the first in_ready is at cycle 63, and the 0101 pattern resumes for zero input.
